// File: rtl/scarv_soc_reset_seq.sv
// Sequenced multi-domain reset generator: PLL-lock gated ordered release,
// per-domain software resets and a last-reset-cause register.
module scarv_soc_reset_seq #(
  parameter int unsigned                  NUM_DOMAINS       = 4,
  parameter int unsigned                  CNT_W             = 8,
  parameter int unsigned                  RESET_CYCLES_BASE = 16,
  parameter logic [NUM_DOMAINS*CNT_W-1:0] RESET_CYCLES_DOM  = {NUM_DOMAINS{CNT_W'(16)}},
  parameter int unsigned                  SW_RESET_CYCLES   = 8
) (
  input  logic                   f_clk,
  input  logic                   g_resetn,
  input  logic                   f_clk_locked,
  input  logic [NUM_DOMAINS-1:0] sw_rst_req,
  output logic [NUM_DOMAINS-1:0] resetn_dom,
  output logic                   seq_busy,
  output logic [1:0]             rst_cause
);

  localparam int unsigned      IDX_W     = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [CNT_W-1:0] BASE_LAST = CNT_W'((RESET_CYCLES_BASE > 1) ? RESET_CYCLES_BASE - 1 : 0);
  localparam logic [CNT_W-1:0] SW_LOAD   = CNT_W'((SW_RESET_CYCLES > 1) ? SW_RESET_CYCLES : 1);

  typedef enum logic [1:0] {HOLD, BASE, STAGE, RUN} state_t;
  typedef enum logic [1:0] {CAUSE_POR = 2'd0, CAUSE_LOCK = 2'd1, CAUSE_SW = 2'd2} cause_t;

  state_t           state;
  logic             lk_meta;
  logic             lk_s;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] stage_last;
  logic [CNT_W-1:0] sw_cnt     [NUM_DOMAINS];
  logic [CNT_W-1:0] sw_cnt_nxt [NUM_DOMAINS];
  logic [NUM_DOMAINS-1:0] dom_run_nxt;

  always_ff @(posedge f_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      lk_meta <= f_clk_locked;
      lk_s    <= lk_meta;
    end
  end

  // Terminal count of the stage currently being timed (zero-length stages last one cycle).
  always_comb begin
    stage_last = '0;
    for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
      if (idx == IDX_W'(i) && RESET_CYCLES_DOM[i*CNT_W +: CNT_W] > CNT_W'(1))
        stage_last = RESET_CYCLES_DOM[i*CNT_W +: CNT_W] - CNT_W'(1);
    end
  end

  // Independent software pulses for domains 1..N-1 while in RUN.
  always_comb begin
    dom_run_nxt = resetn_dom;
    sw_cnt_nxt  = sw_cnt;
    for (int unsigned i = 1; i < NUM_DOMAINS; i++) begin
      if (sw_cnt[i] != '0) begin
        if (sw_cnt[i] == CNT_W'(1)) begin
          dom_run_nxt[i] = 1'b1;
          sw_cnt_nxt[i]  = '0;
        end else begin
          sw_cnt_nxt[i]  = sw_cnt[i] - CNT_W'(1);
        end
      end else if (sw_rst_req[i] && resetn_dom[i]) begin
        dom_run_nxt[i] = 1'b0;
        sw_cnt_nxt[i]  = SW_LOAD;
      end
    end
  end

  always_ff @(posedge f_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state      <= HOLD;
      cnt        <= '0;
      idx        <= '0;
      resetn_dom <= '0;
      seq_busy   <= 1'b1;
      rst_cause  <= CAUSE_POR;
      for (int unsigned i = 0; i < NUM_DOMAINS; i++) sw_cnt[i] <= '0;
    end else if (state != HOLD && !lk_s) begin
      // Lock loss outranks everything and is handled ahead of the per-state logic.
      state      <= HOLD;
      cnt        <= '0;
      resetn_dom <= '0;
      seq_busy   <= 1'b1;
      for (int unsigned i = 0; i < NUM_DOMAINS; i++) sw_cnt[i] <= '0;
      if (state == RUN) rst_cause <= CAUSE_LOCK;
    end else begin
      case (state)
        HOLD: begin
          resetn_dom <= '0;
          seq_busy   <= 1'b1;
          cnt        <= '0;
          if (lk_s) state <= BASE;
        end
        BASE: begin
          if (cnt == BASE_LAST) begin
            state <= STAGE;
            cnt   <= '0;
            idx   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STAGE: begin
          if (cnt == stage_last) begin
            resetn_dom[idx] <= 1'b1;
            cnt             <= '0;
            if (idx == LAST_IDX) begin
              state    <= RUN;
              seq_busy <= 1'b0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (sw_rst_req[0]) begin
            state      <= BASE;
            cnt        <= '0;
            resetn_dom <= '0;
            seq_busy   <= 1'b1;
            rst_cause  <= CAUSE_SW;
            for (int unsigned i = 0; i < NUM_DOMAINS; i++) sw_cnt[i] <= '0;
          end else begin
            resetn_dom <= dom_run_nxt;
            seq_busy   <= ~&dom_run_nxt;
            sw_cnt     <= sw_cnt_nxt;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_scarv_soc_reset_seq.sv
// Scoreboard bench for scarv_soc_reset_seq: default instance plus one with
// a zero-length BASE and a zero-length domain-1 stage, sharing all inputs.
module tb_scarv_soc_reset_seq;

  localparam int unsigned A_BASE = 16;
  localparam logic [31:0] A_DOM  = {4{8'd16}};
  localparam int unsigned B_BASE = 0;
  localparam logic [31:0] B_DOM  = {8'd16, 8'd16, 8'd0, 8'd16};
  localparam int unsigned NOLIM  = 32'hFFFF_FFF0;

  logic       f_clk;
  logic       g_resetn;
  logic       f_clk_locked;
  logic [3:0] sw_rst_req;
  logic [3:0] dom_a, dom_b;
  logic       busy_a, busy_b;
  logic [1:0] cause_a, cause_b;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc      = 0;

  typedef struct {
    int unsigned cyc;
    int unsigned dut;
    logic [3:0]  dom;
    logic        busy;
    logic [1:0]  cause;
  } exp_t;

  exp_t sb[$];

  scarv_soc_reset_seq u_dut_a (
    .f_clk        (f_clk),
    .g_resetn     (g_resetn),
    .f_clk_locked (f_clk_locked),
    .sw_rst_req   (sw_rst_req),
    .resetn_dom   (dom_a),
    .seq_busy     (busy_a),
    .rst_cause    (cause_a)
  );

  scarv_soc_reset_seq #(
    .RESET_CYCLES_BASE (B_BASE),
    .RESET_CYCLES_DOM  (B_DOM)
  ) u_dut_b (
    .f_clk        (f_clk),
    .g_resetn     (g_resetn),
    .f_clk_locked (f_clk_locked),
    .sw_rst_req   (sw_rst_req),
    .resetn_dom   (dom_b),
    .seq_busy     (busy_b),
    .rst_cause    (cause_b)
  );

  initial begin
    f_clk = 1'b0;
    forever #5 f_clk = ~f_clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] low_mask(input int unsigned n);
    logic [3:0] m;
    m = '0;
    for (int unsigned j = 0; j < n && j < 4; j++) m[j] = 1'b1;
    return m;
  endfunction

  // Edges from the BASE-entry edge to the release of domain k.
  function automatic int unsigned rise_off(input int unsigned base, input logic [31:0] doms,
                                           input int unsigned k);
    int unsigned t;
    logic [7:0]  d;
    t = (base > 1) ? base : 1;
    for (int unsigned j = 0; j <= k; j++) begin
      d = doms[j*8 +: 8];
      t += (d > 8'd1) ? int'(d) : 1;
    end
    return t;
  endfunction

  function automatic void expect_at(input int unsigned c, input int unsigned dut,
                                    input logic [3:0] dom, input logic [1:0] cause);
    exp_t        e;
    int unsigned p;
    e.cyc   = c;
    e.dut   = dut;
    e.dom   = dom;
    e.busy  = ~&dom;
    e.cause = cause;
    p = sb.size();
    while (p > 0 && sb[p-1].cyc > c) p--;
    sb.insert(p, e);
  endfunction

  function automatic void expect_both(input int unsigned c, input logic [3:0] dom,
                                      input logic [1:0] cause);
    expect_at(c, 0, dom, cause);
    expect_at(c, 1, dom, cause);
  endfunction

  function automatic void push_sequence(input int unsigned dut, input int unsigned start,
                                        input logic [1:0] cause, input int unsigned lim);
    int unsigned base, r;
    logic [31:0] doms;
    base = (dut == 0) ? A_BASE : B_BASE;
    doms = (dut == 0) ? A_DOM  : B_DOM;
    r    = start;
    if (start + 1 <= lim) expect_at(start + 1, dut, 4'b0000, cause);
    for (int unsigned k = 0; k < 4; k++) begin
      r = start + rise_off(base, doms, k);
      if (r - 1 <= lim) expect_at(r - 1, dut, low_mask(k), cause);
      if (r <= lim)     expect_at(r, dut, low_mask(k + 1), cause);
    end
    if (r + 2 <= lim) expect_at(r + 2, dut, 4'b1111, cause);
  endfunction

  task automatic wait_edge(input int unsigned n);
    while (cyc < n) @(negedge f_clk);
  endtask

  // Monitor: counts rising edges and retires every expectation due on this edge.
  initial begin
    exp_t       e;
    logic [3:0] od;
    logic       ob;
    logic [1:0] oc;
    string      tag;
    forever begin
      @(posedge f_clk);
      cyc++;
      #1;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.dut == 0) begin od = dom_a; ob = busy_a; oc = cause_a; end
        else            begin od = dom_b; ob = busy_b; oc = cause_b; end
        tag = $sformatf("dut%0d@%0d", e.dut, e.cyc);
        if (e.cyc < cyc) check_eq({tag, ".late"}, cyc, e.cyc);
        else begin
          check_eq({tag, ".dom"},   od, e.dom);
          check_eq({tag, ".busy"},  ob, e.busy);
          check_eq({tag, ".cause"}, oc, e.cause);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned e0, d0, s, t, e1;

    g_resetn     = 1'b1;
    f_clk_locked = 1'b1;
    sw_rst_req   = '0;
    #1 g_resetn  = 1'b0;
    #2;
    check_eq("por_dom_a",   dom_a,   4'b0000);
    check_eq("por_busy_a",  busy_a,  1'b1);
    check_eq("por_cause_a", cause_a, 2'd0);
    check_eq("por_dom_b",   dom_b,   4'b0000);
    check_eq("por_busy_b",  busy_b,  1'b1);

    // Power-on release with lock already stable.
    repeat (3) @(negedge f_clk);
    g_resetn = 1'b1;
    e0 = cyc;
    expect_both(e0 + 2, 4'b0000, 2'd0);
    push_sequence(0, e0 + 3, 2'd0, NOLIM);
    push_sequence(1, e0 + 3, 2'd0, NOLIM);
    wait_edge(e0 + 88);

    // Lock dropped for 5 sampled edges while in RUN.
    d0 = cyc;
    f_clk_locked = 1'b0;
    expect_both(d0 + 2, 4'b1111, 2'd0);
    expect_both(d0 + 3, 4'b0000, 2'd1);
    expect_both(d0 + 5, 4'b0000, 2'd1);
    wait_edge(d0 + 5);
    f_clk_locked = 1'b1;
    push_sequence(0, d0 + 8, 2'd1, NOLIM);
    push_sequence(1, d0 + 8, 2'd1, NOLIM);
    wait_edge(d0 + 8 + 85);

    // One-cycle software request on domain 2.
    s = cyc;
    sw_rst_req = 4'b0100;
    for (int unsigned k = 1; k <= 8; k++) expect_both(s + k, 4'b1011, 2'd1);
    expect_both(s + 9,  4'b1111, 2'd1);
    expect_both(s + 10, 4'b1111, 2'd1);
    @(negedge f_clk);
    sw_rst_req = '0;
    wait_edge(s + 14);

    // Domains 1 and 3 together, then domain 0 three cycles later.
    t = cyc;
    sw_rst_req = 4'b1010;
    for (int unsigned k = 1; k <= 3; k++) expect_both(t + k, 4'b0101, 2'd1);
    wait_edge(t + 3);
    sw_rst_req = 4'b1011;
    expect_both(t + 4, 4'b0000, 2'd2);
    wait_edge(t + 4);
    sw_rst_req = '0;
    push_sequence(0, t + 4, 2'd2, t + 60);
    push_sequence(1, t + 4, 2'd2, t + 60);
    wait_edge(t + 60);

    // Asynchronous reset while domain A is timing stage 2.
    #2 g_resetn = 1'b0;
    #1;
    check_eq("async_dom_a",   dom_a,   4'b0000);
    check_eq("async_busy_a",  busy_a,  1'b1);
    check_eq("async_cause_a", cause_a, 2'd0);
    check_eq("async_dom_b",   dom_b,   4'b0000);
    check_eq("async_cause_b", cause_b, 2'd0);
    repeat (2) @(negedge f_clk);
    g_resetn = 1'b1;
    e1 = cyc;
    expect_both(e1 + 2, 4'b0000, 2'd0);
    push_sequence(0, e1 + 3, 2'd0, NOLIM);
    push_sequence(1, e1 + 3, 2'd0, NOLIM);

    // Requests outside RUN must not disturb the sequence.
    wait_edge(e1 + 40);
    sw_rst_req = 4'b0101;
    wait_edge(e1 + 42);
    sw_rst_req = '0;
    wait_edge(e1 + 3 + 85);

    check_eq("drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
